// File: rtl/buffer_tristate_pkg.sv
// rtl/buffer_tristate_pkg.sv - shared constants for the tri-state output buffer
package buffer_tristate_pkg;

  localparam int DEFAULT_WIDTH = 1;

  // Values of the REGISTERED parameter
  localparam int MODE_COMB = 0;
  localparam int MODE_REG  = 1;

endpackage

// File: rtl/buffer_tristate_if.sv
// rtl/buffer_tristate_if.sv - internal-side signals of the tri-state buffer
interface buffer_tristate_if
  import buffer_tristate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic [WIDTH-1:0] in;
  logic             enable;
  logic             drive_active;
  logic [WIDTH-1:0] bus_readback;

  modport master (
    output in,
    output enable,
    input  drive_active,
    input  bus_readback
  );

  modport slave (
    input  in,
    input  enable,
    output drive_active,
    output bus_readback
  );

endinterface

// File: rtl/buffer_tristate_drv.sv
// rtl/buffer_tristate_drv.sv - WIDTH-bit tri-state driver (data, oe -> out)
// Optional BUFFER_TRISTATE_WEAK_LOW_EN: pull the net weakly low when released.
module buffer_tristate_drv
  import buffer_tristate_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] data,
  input  logic             oe,
  inout  tri   [WIDTH-1:0] out
);

`ifdef BUFFER_TRISTATE_WEAK_LOW_EN
  assign out = oe ? data : {WIDTH{1'bz}};
  // Always-on pull0 keeper; any strong driver (ours or external) overrides it
  assign (pull0, highz1) out = {WIDTH{1'b0}};
`else
  assign out = oe ? data : {WIDTH{1'bz}};
`endif

endmodule

// File: rtl/buffer_tristate.sv
// rtl/buffer_tristate.sv - tri-state output buffer with optional one-cycle registered mode
// Optional BUFFER_TRISTATE_WEAK_LOW_EN (see buffer_tristate_drv): weak-low when released.
module buffer_tristate
  import buffer_tristate_pkg::*;
#(
  parameter int WIDTH      = DEFAULT_WIDTH,
  parameter int REGISTERED = MODE_COMB
) (
  input  logic              Clk,
  input  logic              Rst_n,
  buffer_tristate_if.slave  bus,
  inout  tri   [WIDTH-1:0]  out
);

  logic             rst_done;
  logic [WIDTH-1:0] drv_data;
  logic             drv_oe;

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      rst_done <= 1'b0;
    end else begin
      rst_done <= 1'b1;
    end
  end

  generate
    if (REGISTERED == MODE_REG) begin : g_reg
      logic [WIDTH-1:0] in_q;
      logic             en_q;

      always_ff @(posedge Clk) begin
        if (!Rst_n) begin
          in_q <= '0;
          en_q <= 1'b0;
        end else begin
          in_q <= bus.in;
          en_q <= bus.enable;
        end
      end

      // en_q can only be set on an edge where rst_done is also set, so the
      // AND never changes behaviour; it keeps the release gating in one place.
      assign drv_data = in_q;
      assign drv_oe   = en_q & rst_done;
    end else begin : g_comb
      assign drv_data = bus.in;
      assign drv_oe   = bus.enable & rst_done;
    end
  endgenerate

  buffer_tristate_drv #(
    .WIDTH (WIDTH)
  ) u_drv (
    .data (drv_data),
    .oe   (drv_oe),
    .out  (out)
  );

  assign bus.drive_active = drv_oe;
  assign bus.bus_readback = out;

endmodule

// File: tb/tb_buffer_tristate.sv
// tb/tb_buffer_tristate.sv - directed bench for buffer_tristate (comb, registered, 8-bit)
module tb_buffer_tristate;
  import buffer_tristate_pkg::*;

  logic Clk;
  logic Rst_n;

  logic       tin;
  logic       ten;
  logic [7:0] tin8;
  logic       ten8;

  logic       ext0_en, ext0_val;
  logic       ext1_en, ext1_val;
  logic       ext8_en;
  logic [7:0] ext8_val;

  tri [0:0] out0;
  tri [0:0] out1;
  tri [7:0] out8;

  int checks;
  int errors;

  buffer_tristate_if #(.WIDTH(1)) b0 ();
  buffer_tristate_if #(.WIDTH(1)) b1 ();
  buffer_tristate_if #(.WIDTH(8)) b8 ();

  assign b0.in     = tin;
  assign b0.enable = ten;
  assign b1.in     = tin;
  assign b1.enable = ten;
  assign b8.in     = tin8;
  assign b8.enable = ten8;

  // Other bus drivers sharing each net
  assign out0 = ext0_en ? ext0_val : 1'bz;
  assign out1 = ext1_en ? ext1_val : 1'bz;
  assign out8 = ext8_en ? ext8_val : 8'bzzzz_zzzz;

  buffer_tristate #(.WIDTH(1), .REGISTERED(MODE_COMB)) dut0 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b0),
    .out   (out0)
  );

  buffer_tristate #(.WIDTH(1), .REGISTERED(MODE_REG)) dut1 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b1),
    .out   (out1)
  );

  buffer_tristate #(.WIDTH(8), .REGISTERED(MODE_COMB)) dut8 (
    .Clk   (Clk),
    .Rst_n (Rst_n),
    .bus   (b8),
    .out   (out8)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    Rst_n    = 1'b0;
    tin      = 1'b1;
    ten      = 1'b1;
    tin8     = 8'h00;
    ten8     = 1'b0;
    ext0_en  = 1'b0;
    ext0_val = 1'b0;
    ext1_en  = 1'b0;
    ext1_val = 1'b0;
    ext8_en  = 1'b0;
    ext8_val = 8'h00;

    // Reset held for two edges with enable=1, in=1: nothing drives
    @(negedge Clk);
    @(negedge Clk);
    check("rst_da0", {7'b0, b0.drive_active}, 8'h00);
    check("rst_da1", {7'b0, b1.drive_active}, 8'h00);
    check("rst_da8", {7'b0, b8.drive_active}, 8'h00);
    ext0_en = 1'b1; ext0_val = 1'b0;
    ext1_en = 1'b1; ext1_val = 1'b0;
    #1;
    check("rst_rb0_released", {7'b0, b0.bus_readback}, 8'h00);
    check("rst_rb1_released", {7'b0, b1.bus_readback}, 8'h00);
    ext0_en = 1'b0;
    ext1_en = 1'b0;

    // Release: drive starts at the first edge with Rst_n high
    @(negedge Clk);
    Rst_n = 1'b1;
    #1;
    check("rel_da0_pre", {7'b0, b0.drive_active}, 8'h00);
    check("rel_da1_pre", {7'b0, b1.drive_active}, 8'h00);
    @(negedge Clk);
    check("rel_da0", {7'b0, b0.drive_active}, 8'h01);
    check("rel_rb0", {7'b0, b0.bus_readback}, 8'h01);
    check("rel_da1", {7'b0, b1.drive_active}, 8'h01);
    check("rel_rb1", {7'b0, b1.bus_readback}, 8'h01);

    // in=0, enable=0: mode 0 releases now, mode 1 at the next edge
    tin = 1'b0; ten = 1'b0;
    #1;
    check("m0_off_da", {7'b0, b0.drive_active}, 8'h00);
    check("m1_off_da_hold", {7'b0, b1.drive_active}, 8'h01);
    check("m1_off_rb_hold", {7'b0, b1.bus_readback}, 8'h01);
    @(negedge Clk);
    check("m1_off_da", {7'b0, b1.drive_active}, 8'h00);

    // enable=1 with in=0
    ten = 1'b1;
    #1;
    check("m0_en_da", {7'b0, b0.drive_active}, 8'h01);
    check("m0_en_rb", {7'b0, b0.bus_readback}, 8'h00);
    check("m1_en_da_hold", {7'b0, b1.drive_active}, 8'h00);
    @(negedge Clk);
    check("m1_en_da", {7'b0, b1.drive_active}, 8'h01);
    check("m1_en_rb", {7'b0, b1.bus_readback}, 8'h00);

    // in=1 while enabled
    tin = 1'b1;
    #1;
    check("m0_in1_rb", {7'b0, b0.bus_readback}, 8'h01);
    check("m1_in1_rb_hold", {7'b0, b1.bus_readback}, 8'h00);
    @(negedge Clk);
    check("m1_in1_rb", {7'b0, b1.bus_readback}, 8'h01);

    // enable=0 with in=1: another driver pulling 0 must win once released
    ten = 1'b0;
    ext0_en = 1'b1; ext0_val = 1'b0;
    #1;
    check("m0_dis_da", {7'b0, b0.drive_active}, 8'h00);
    check("m0_dis_rb_ext", {7'b0, b0.bus_readback}, 8'h00);
    check("m1_dis_da_hold", {7'b0, b1.drive_active}, 8'h01);
    @(negedge Clk);
    ext1_en = 1'b1; ext1_val = 1'b0;
    #1;
    check("m1_dis_da", {7'b0, b1.drive_active}, 8'h00);
    check("m1_dis_rb_ext", {7'b0, b1.bus_readback}, 8'h00);
    ext0_val = 1'b1;
    #1;
    check("m0_ext1_rb", {7'b0, b0.bus_readback}, 8'h01);
    ext0_en = 1'b0;
    ext1_en = 1'b0;

    // Mid-operation reset while driving 1
    ten = 1'b1;
    @(negedge Clk);
    check("mid_da0_run", {7'b0, b0.drive_active}, 8'h01);
    check("mid_da1_run", {7'b0, b1.drive_active}, 8'h01);
    Rst_n = 1'b0;
    #1;
    check("mid_da0_presample", {7'b0, b0.drive_active}, 8'h01);
    @(negedge Clk);
    ext0_en = 1'b1; ext0_val = 1'b0;
    ext1_en = 1'b1; ext1_val = 1'b0;
    #1;
    check("mid_da0_rst", {7'b0, b0.drive_active}, 8'h00);
    check("mid_da1_rst", {7'b0, b1.drive_active}, 8'h00);
    check("mid_rb0_rst", {7'b0, b0.bus_readback}, 8'h00);
    check("mid_rb1_rst", {7'b0, b1.bus_readback}, 8'h00);
    ext0_en = 1'b0;
    ext1_en = 1'b0;
    Rst_n = 1'b1;
    #1;
    check("mid_da0_relpre", {7'b0, b0.drive_active}, 8'h00);
    @(negedge Clk);
    check("mid_da0_resume", {7'b0, b0.drive_active}, 8'h01);
    check("mid_rb0_resume", {7'b0, b0.bus_readback}, 8'h01);
    check("mid_da1_resume", {7'b0, b1.drive_active}, 8'h01);
    check("mid_rb1_resume", {7'b0, b1.bus_readback}, 8'h01);

    // 8-bit instance: all bits share one enable
    tin8 = 8'hA5; ten8 = 1'b1;
    #1;
    check("w8_da", {7'b0, b8.drive_active}, 8'h01);
    check("w8_rb", b8.bus_readback, 8'hA5);
    tin8 = 8'h3C;
    #1;
    check("w8_rb_chg", b8.bus_readback, 8'h3C);
    tin8 = 8'hA5;
    ten8 = 1'b0;
    ext8_en = 1'b1; ext8_val = 8'h5A;
    #1;
    check("w8_off_da", {7'b0, b8.drive_active}, 8'h00);
    check("w8_off_rb_ext", b8.bus_readback, 8'h5A);
    ext8_en = 1'b0;

`ifdef BUFFER_TRISTATE_WEAK_LOW_EN
    #1;
    check("weak_rb_low", b8.bus_readback, 8'h00);
    check("weak_da", {7'b0, b8.drive_active}, 8'h00);
    ext8_en = 1'b1; ext8_val = 8'hFF;
    #1;
    check("weak_rb_ext", b8.bus_readback, 8'hFF);
    ext8_en = 1'b0;
`endif

    @(negedge Clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
